// File: rtl/jr_hazard_ctrl_pkg.sv
// rtl/jr_hazard_ctrl_pkg.sv - shared states, forward-select codes and stall depths (option: JR_WB_FWD_EN)
package mips_hazard_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STALL   = 2'd1,
      RESOLVE = 2'd2
   } jr_state_e;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   // The EX result never feeds the jump mux, so an EX ALU producer always waits one cycle
   localparam int STALL_EX_ALU = 1;

`ifdef JR_WB_FWD_EN
   localparam int STALL_EX_LOAD  = 2;
   localparam int STALL_MEM_LOAD = 1;
   localparam int STALL_WB_ONLY  = 0;
`else
   // Without the WB path the value must first land in the regfile at the end of WB
   localparam int STALL_EX_LOAD  = 3;
   localparam int STALL_MEM_LOAD = 2;
   localparam int STALL_WB_ONLY  = 1;
`endif

endpackage

// File: rtl/jr_hazard_ctrl_dep_check.sv
// rtl/jr_hazard_ctrl_dep_check.sv - combinational match of a jr source against EX/MEM/WB writes
module jr_dep_check
   import mips_hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  mem_reg_write,
   input  logic                  mem_mem_read,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  ex_match,
   output logic                  ex_load,
   output logic                  mem_match,
   output logic                  mem_load,
   output logic                  wb_match
);

   logic rs_nz;

   // $0 is hardwired, so it never depends on anything in flight
   assign rs_nz     = |rs;
   assign ex_match  = ex_reg_write  & (ex_rd  == rs) & rs_nz;
   assign mem_match = mem_reg_write & (mem_rd == rs) & rs_nz;
   assign wb_match  = wb_reg_write  & (wb_rd  == rs) & rs_nz;
   assign ex_load   = ex_match  & ex_mem_read;
   assign mem_load  = mem_match & mem_mem_read;

endmodule

// File: rtl/jr_hazard_ctrl.sv
// rtl/jr_hazard_ctrl.sv - jr/jalr stall, bubble and forward-select control (option: JR_WB_FWD_EN)
module jr_hazard_ctrl
   import mips_hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_is_jr,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  mem_reg_write,
   input  logic                  mem_mem_read,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   output logic [1:0]            fwd_sel,
   output logic                  pc_stall,
   output logic                  ifid_stall,
   output logic                  idex_bubble,
   output logic                  jr_taken
);

   jr_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [REG_ADDR_W-1:0] rs_q, rs_d;
   logic [REG_ADDR_W-1:0] rs_chk;
   logic [CNT_W-1:0]      need_n;
   logic [CNT_W-1:0]      cnt_init;
   logic [1:0]            fwd_pick;
   logic                  stall;
   logic                  ex_match, ex_load, mem_match, mem_load, wb_match;

   // Once a jr is parked, ID may change underneath it; compare against the latched operand
   assign rs_chk = (state_q == IDLE) ? id_rs : rs_q;

   jr_dep_check #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_dep_check (
      .rs            (rs_chk),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .ex_rd         (ex_rd),
      .mem_reg_write (mem_reg_write),
      .mem_mem_read  (mem_mem_read),
      .mem_rd        (mem_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .ex_match      (ex_match),
      .ex_load       (ex_load),
      .mem_match     (mem_match),
      .mem_load      (mem_load),
      .wb_match      (wb_match)
   );

   // Stall depth for a fresh jr: the youngest producer decides
   always_comb begin
      need_n = '0;
      if (ex_match) begin
         need_n = ex_load ? CNT_W'(STALL_EX_LOAD) : CNT_W'(STALL_EX_ALU);
      end else if (mem_match) begin
         need_n = mem_load ? CNT_W'(STALL_MEM_LOAD) : '0;
      end else if (wb_match) begin
         need_n = CNT_W'(STALL_WB_ONLY);
      end
   end

   assign cnt_init = need_n - CNT_W'(1);

   // Jump-mux source when the target resolves this cycle; MEM outranks WB
   always_comb begin
      fwd_pick = FWD_RF;
      if (mem_match && !mem_load) begin
         fwd_pick = FWD_MEM;
      end
`ifdef JR_WB_FWD_EN
      else if (wb_match) begin
         fwd_pick = FWD_WB;
      end
`endif
   end

   // State, countdown and latched source register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rs_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rs_q    <= rs_d;
      end
   end

   // Next state and Mealy outputs; held quiet while reset is asserted
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rs_d     = rs_q;
      stall    = 1'b0;
      jr_taken = 1'b0;
      fwd_sel  = FWD_RF;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               if (id_is_jr) begin
                  if (need_n == '0) begin
                     jr_taken = 1'b1;
                     fwd_sel  = fwd_pick;
                  end else begin
                     stall   = 1'b1;
                     rs_d    = id_rs;
                     cnt_d   = cnt_init;
                     state_d = (cnt_init != '0) ? STALL : RESOLVE;
                  end
               end
            end
            STALL: begin
               stall = 1'b1;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = RESOLVE;
               end
            end
            RESOLVE: begin
               jr_taken = 1'b1;
               fwd_sel  = fwd_pick;
               cnt_d    = '0;
               state_d  = IDLE;
            end
            default: begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   assign pc_stall    = stall;
   assign ifid_stall  = stall;
   assign idex_bubble = stall;

endmodule

// File: tb/tb_jr_hazard_ctrl.sv
// tb/tb_jr_hazard_ctrl.sv - pipeline-model bench for jr_hazard_ctrl (option: JR_WB_FWD_EN)
module tb_jr_hazard_ctrl;

   typedef struct packed {
      logic       wr;
      logic       ld;
      logic [4:0] rd;
   } ins_t;

   localparam ins_t NOP = '0;
`ifdef JR_WB_FWD_EN
   localparam bit WB_FWD = 1'b1;
`else
   localparam bit WB_FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_is_jr;
   logic [4:0] id_rs;
   ins_t       ex_s, mem_s, wb_s, id_ins;
   logic [1:0] fwd_sel;
   logic       pc_stall, ifid_stall, idex_bubble, jr_taken;

   int   tests  = 0;
   int   failed = 0;
   bit   rand_id = 1'b0;
   logic obs_stall, obs_taken;
   logic [1:0] obs_fwd;
   int   nstall;
   logic done;
   logic [1:0] fin_fwd;

   always #5 clk = ~clk;

   jr_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .id_is_jr      (id_is_jr),
      .id_rs         (id_rs),
      .ex_reg_write  (ex_s.wr),
      .ex_mem_read   (ex_s.ld),
      .ex_rd         (ex_s.rd),
      .mem_reg_write (mem_s.wr),
      .mem_mem_read  (mem_s.ld),
      .mem_rd        (mem_s.rd),
      .wb_reg_write  (wb_s.wr),
      .wb_rd         (wb_s.rd),
      .fwd_sel       (fwd_sel),
      .pc_stall      (pc_stall),
      .ifid_stall    (ifid_stall),
      .idex_bubble   (idex_bubble),
      .jr_taken      (jr_taken)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Where is the youngest in-flight producer of id_rs, and can its value reach the jump mux now?
   // ALU results are usable from MEM on, load data from WB on; WB itself only with the WB path,
   // otherwise once the producer has retired into the regfile.
   function automatic void model(output logic s, output logic t, output logic [1:0] f);
      int   stage = 0;
      logic ld    = 1'b0;
      logic ready;
      s = 1'b0; t = 1'b0; f = 2'd0;
      if (!id_is_jr) return;
      if (id_rs != 5'd0) begin
         if (ex_s.wr && ex_s.rd == id_rs) begin stage = 1; ld = ex_s.ld; end
         else if (mem_s.wr && mem_s.rd == id_rs) begin stage = 2; ld = mem_s.ld; end
         else if (wb_s.wr && wb_s.rd == id_rs) begin stage = 3; end
      end
      ready = (stage == 0) || (stage == 2 && !ld) || (stage == 3 && WB_FWD);
      if (ready) begin
         t = 1'b1;
         f = (stage == 2) ? 2'd2 : (stage == 3) ? 2'd3 : 2'd0;
      end else begin
         s = 1'b1;
      end
   endfunction

   function automatic ins_t rand_ins();
      ins_t r;
      r.wr = ($urandom % 4) != 0;
      r.ld = ($urandom % 3) == 0;
      r.rd = 5'($urandom_range(0, 7));
      return r;
   endfunction

   task automatic new_id();
      if (rand_id) begin
         id_is_jr = 1'($urandom_range(0, 1));
         id_rs    = 5'($urandom_range(0, 7));
         id_ins   = rand_ins();
      end else begin
         id_is_jr = 1'b0;
         id_rs    = 5'd0;
         id_ins   = NOP;
      end
   endtask

   task automatic clear_pipe();
      ex_s = NOP; mem_s = NOP; wb_s = NOP;
   endtask

   // One cycle: predict, compare mid-cycle, then advance the pipeline model
   task automatic step(input string tag);
      logic s, t;
      logic [1:0] f;
      model(s, t, f);
      @(negedge clk);
      check({tag, ".pc_stall"},    8'(pc_stall),    8'(s));
      check({tag, ".ifid_stall"},  8'(ifid_stall),  8'(s));
      check({tag, ".idex_bubble"}, 8'(idex_bubble), 8'(s));
      check({tag, ".jr_taken"},    8'(jr_taken),    8'(t));
      check({tag, ".fwd_sel"},     8'(fwd_sel),     8'(f));
      obs_stall = pc_stall;
      obs_taken = jr_taken;
      obs_fwd   = fwd_sel;
      @(posedge clk);
      #1;
      wb_s  = mem_s;
      mem_s = ex_s;
      if (s) begin
         ex_s = NOP;
      end else begin
         ex_s = id_is_jr ? NOP : id_ins;
         new_id();
      end
   endtask

   task automatic run_jr(input string tag);
      nstall = 0; done = 1'b0; fin_fwd = 2'd0;
      for (int i = 0; i < 6 && !done; i++) begin
         step(tag);
         if (obs_stall) nstall++;
         if (obs_taken) begin done = 1'b1; fin_fwd = obs_fwd; end
      end
      check({tag, ".resolved"}, 8'(done), 8'd1);
   endtask

   initial begin
      clear_pipe();
      id_ins   = NOP;
      id_is_jr = 1'b1;
      id_rs    = 5'd8;
      mem_s    = '{wr: 1'b1, ld: 1'b0, rd: 5'd8};

      // reset holds every output low even with a jr presented
      @(negedge clk);
      check("rst.pc_stall",    8'(pc_stall),    8'd0);
      check("rst.ifid_stall",  8'(ifid_stall),  8'd0);
      check("rst.idex_bubble", 8'(idex_bubble), 8'd0);
      check("rst.jr_taken",    8'(jr_taken),    8'd0);
      check("rst.fwd_sel",     8'(fwd_sel),     8'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      clear_pipe();
      new_id();
      step("idle");

      // no hazard
      id_is_jr = 1'b1; id_rs = 5'd8;
      run_jr("nomatch");
      check("nomatch.stalls", 8'(nstall), 8'd0);
      check("nomatch.fwd", 8'(fin_fwd), 8'd0);

      // MEM ALU producer
      clear_pipe(); mem_s = '{wr: 1'b1, ld: 1'b0, rd: 5'd8};
      id_is_jr = 1'b1; id_rs = 5'd8;
      run_jr("memalu");
      check("memalu.stalls", 8'(nstall), 8'd0);
      check("memalu.fwd", 8'(fin_fwd), 8'd2);

      // EX load producer
      clear_pipe(); ex_s = '{wr: 1'b1, ld: 1'b1, rd: 5'd8};
      id_is_jr = 1'b1; id_rs = 5'd8;
      run_jr("exload");
      check("exload.stalls", 8'(nstall), WB_FWD ? 8'd2 : 8'd3);
      check("exload.fwd", 8'(fin_fwd), WB_FWD ? 8'd3 : 8'd0);

      // MEM load producer
      clear_pipe(); mem_s = '{wr: 1'b1, ld: 1'b1, rd: 5'd8};
      id_is_jr = 1'b1; id_rs = 5'd8;
      run_jr("memload");
      check("memload.stalls", 8'(nstall), WB_FWD ? 8'd1 : 8'd2);
      check("memload.fwd", 8'(fin_fwd), WB_FWD ? 8'd3 : 8'd0);

      // WB-only producer
      clear_pipe(); wb_s = '{wr: 1'b1, ld: 1'b0, rd: 5'd8};
      id_is_jr = 1'b1; id_rs = 5'd8;
      run_jr("wbonly");
      check("wbonly.stalls", 8'(nstall), WB_FWD ? 8'd0 : 8'd1);
      check("wbonly.fwd", 8'(fin_fwd), WB_FWD ? 8'd3 : 8'd0);

      // $0 never matches
      clear_pipe(); ex_s = '{wr: 1'b1, ld: 1'b1, rd: 5'd0};
      id_is_jr = 1'b1; id_rs = 5'd0;
      run_jr("r0");
      check("r0.stalls", 8'(nstall), 8'd0);
      check("r0.fwd", 8'(fin_fwd), 8'd0);

      // EX ALU producer; the ID operand changes during the stall and must be ignored
      clear_pipe(); ex_s = '{wr: 1'b1, ld: 1'b0, rd: 5'd9};
      id_is_jr = 1'b1; id_rs = 5'd9;
      step("exalu");
      check("exalu.stall", 8'(obs_stall), 8'd1);
      id_rs = 5'd5;
      @(negedge clk);
      check("exalu.res_taken", 8'(jr_taken), 8'd1);
      check("exalu.res_fwd",   8'(fwd_sel),  8'd2);
      check("exalu.res_stall", 8'(pc_stall), 8'd0);
      @(posedge clk); #1;
      wb_s = mem_s; mem_s = ex_s; ex_s = NOP;
      new_id();
      step("exalu.after");

      // reset pulsed in the first stall cycle
      clear_pipe(); ex_s = '{wr: 1'b1, ld: 1'b1, rd: 5'd8};
      id_is_jr = 1'b1; id_rs = 5'd8;
      step("rstmid");
      check("rstmid.stall", 8'(obs_stall), 8'd1);
      #2;
      check("rstmid.pre", 8'(pc_stall), 8'd1);
      rst = 1'b1;
      #1;
      check("rstmid.pc_stall",    8'(pc_stall),    8'd0);
      check("rstmid.ifid_stall",  8'(ifid_stall),  8'd0);
      check("rstmid.idex_bubble", 8'(idex_bubble), 8'd0);
      check("rstmid.jr_taken",    8'(jr_taken),    8'd0);
      check("rstmid.fwd_sel",     8'(fwd_sel),     8'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_pipe();
      id_is_jr = 1'b1; id_rs = 5'd3;
      step("rstmid.new");
      check("rstmid.new_taken", 8'(obs_taken), 8'd1);
      check("rstmid.new_stall", 8'(obs_stall), 8'd0);

      // random instruction stream through the pipeline model
      rand_id = 1'b1;
      clear_pipe();
      new_id();
      for (int i = 0; i < 400; i++) begin
         step("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
